// File: rtl/bitser_pkg.sv
// Shared definitions for the bit-serial logic sequencer: the opcode map of the
// 1-bit logic unit and the sequencer state encoding.
package bitser_pkg;

   localparam logic [2:0] OP_NOT      = 3'b000;
   localparam logic [2:0] OP_NOR      = 3'b001;
   localparam logic [2:0] OP_AND      = 3'b010;
   localparam logic [2:0] OP_OR       = 3'b011;
   localparam logic [2:0] OP_XOR      = 3'b100;
   localparam logic [2:0] OP_XNOR     = 3'b101;
   localparam logic [2:0] OP_NAND     = 3'b110;
   localparam logic [2:0] OP_NAND_ALT = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/bit_logic_unit.sv
// Combinational 1-bit, 8-function logic unit; the sequencer reuses this single
// gate network for every bit position of a wide operation.
module bit_logic_unit
   import bitser_pkg::*;
(
   input  logic       a,
   input  logic       b,
   input  logic [2:0] sel,
   output logic       y
);

   always_comb begin
      y = 1'b0;
      unique case (sel)
         OP_NOT:      y = ~a;
         OP_NOR:      y = ~(a | b);
         OP_AND:      y = a & b;
         OP_OR:       y = a | b;
         OP_XOR:      y = a ^ b;
         OP_XNOR:     y = ~(a ^ b);
         OP_NAND:     y = ~(a & b);
         OP_NAND_ALT: y = ~(a & b);
         default:     y = 1'b0;
      endcase
   end

endmodule

// File: rtl/bitser_logic_seq.sv
// Bit-serial sequencer: accepts two WIDTH-bit operands and an opcode, evaluates
// them LSB-first through one bit_logic_unit and returns the assembled result.
module bitser_logic_seq
   import bitser_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic [2:0]       op_sel,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic             busy,
   output logic [CNT_W-1:0] ops_done
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   state_t           state_reg;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [2:0]       sel_reg;
   logic [CW-1:0]    cnt_reg;
   logic [WIDTH-1:0] res_reg;
   logic             res_valid_reg;
   logic             in_ready_reg;
   logic             busy_reg;
   logic [CNT_W-1:0] ops_done_reg;
   logic             bit_y;

   bit_logic_unit u_blu (
      .a   (a_reg[0]),
      .b   (b_reg[0]),
      .sel (sel_reg),
      .y   (bit_y)
   );

   // All handshake/status outputs are registered alongside the state so they
   // change only on clock edges (or immediately on asynchronous reset).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= ST_IDLE;
         a_reg         <= '0;
         b_reg         <= '0;
         sel_reg       <= OP_NOT;
         cnt_reg       <= '0;
         res_reg       <= '0;
         res_valid_reg <= 1'b0;
         in_ready_reg  <= 1'b1;
         busy_reg      <= 1'b0;
         ops_done_reg  <= '0;
      end else if (flush) begin
         state_reg     <= ST_IDLE;
         cnt_reg       <= '0;
         res_valid_reg <= 1'b0;
         in_ready_reg  <= 1'b1;
         busy_reg      <= 1'b0;
      end else begin
         unique case (state_reg)
            ST_IDLE: begin
               if (in_valid && in_ready_reg) begin
                  a_reg        <= op_a;
                  b_reg        <= op_b;
                  sel_reg      <= op_sel;
                  cnt_reg      <= '0;
                  state_reg    <= ST_RUN;
                  in_ready_reg <= 1'b0;
                  busy_reg     <= 1'b1;
               end
            end
            ST_RUN: begin
               // Result fills from the MSB end so bit 0 lands at bit 0 after WIDTH shifts.
               res_reg <= {bit_y, res_reg[WIDTH-1:1]};
               a_reg   <= a_reg >> 1;
               b_reg   <= b_reg >> 1;
               if (cnt_reg == LAST_BIT) begin
                  cnt_reg       <= '0;
                  state_reg     <= ST_DONE;
                  res_valid_reg <= 1'b1;
               end else begin
                  cnt_reg <= cnt_reg + CW'(1);
               end
            end
            ST_DONE: begin
               if (res_ready) begin
                  state_reg     <= ST_IDLE;
                  res_valid_reg <= 1'b0;
                  in_ready_reg  <= 1'b1;
                  busy_reg      <= 1'b0;
                  ops_done_reg  <= ops_done_reg + CNT_W'(1);
               end
            end
            default: begin
               state_reg     <= ST_IDLE;
               cnt_reg       <= '0;
               res_valid_reg <= 1'b0;
               in_ready_reg  <= 1'b1;
               busy_reg      <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_reg;
   assign res_valid = res_valid_reg;
   assign res_data  = res_reg;
   assign busy      = busy_reg;
   assign ops_done  = ops_done_reg;

endmodule
